// File: rtl/imm_extract_pkg.sv
// Shared types and immediate expansion for the immediate-insertion issue stage.
package imm_extract_pkg;

    localparam int IMM_LEN = 20;

    typedef enum logic [2:0] {
        NONE = 3'd0,
        I    = 3'd1,
        S    = 3'd2,
        B    = 3'd3,
        U    = 3'd4,
        J    = 3'd5,
        Z    = 3'd6
    } imm_type_e;

    // Every expansion fits in 32 bits with correct sign, so callers sign-extend this to XLEN.
    function automatic logic signed [31:0] imm_expand(input logic [IMM_LEN-1:0] imm,
                                                      input imm_type_e     t);
        logic signed [31:0] r;
        case (t)
            I, S:    r = {{20{imm[11]}}, imm[11:0]};
            B:       r = {{19{imm[11]}}, imm[11:0], 1'b0};
            U:       r = {imm, 12'b0};
            J:       r = {{11{imm[19]}}, imm, 1'b0};
            Z:       r = {27'b0, imm[4:0]};
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic imm_replaces(input imm_type_e t);
        return t inside {I, S, B, U, J, Z};
    endfunction

endpackage

// File: rtl/imm_skid_buf2.sv
// Two-entry skid buffer; in_ready comes only from the registered entry count.
module imm_skid_buf2 #(
    parameter int WIDTH = 192
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [1:0]       cnt_p1;
    logic [WIDTH-1:0] head_p1;
    logic [WIDTH-1:0] tail_p1;
    logic             push;
    logic             pop;

    assign in_ready  = (cnt_p1 < 2'd2);
    assign out_valid = (cnt_p1 != 2'd0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    // Stage p1: entry count is the only reset state
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            cnt_p1 <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10:   cnt_p1 <= cnt_p1 + 2'd1;
                2'b01:   cnt_p1 <= cnt_p1 - 2'd1;
                default: cnt_p1 <= cnt_p1;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push && (cnt_p1 == 2'd0 || pop)) begin
            head_p1 <= in_data;
        end else if (pop && cnt_p1 == 2'd2) begin
            head_p1 <= tail_p1;
        end
        if (push && !pop && cnt_p1 == 2'd1) begin
            tail_p1 <= in_data;
        end
    end

    // Data registers are not reset, so the output is gated to zero while empty.
    assign out_data = out_valid ? head_p1 : '0;

endmodule

// File: rtl/imm_extract_stage.sv
// Immediate-insertion stage: expand the compacted immediate, replace one source, buffer in a skid buffer.
// Optional flush port enabled by defining IMM_FLUSH_EN.
module imm_extract_stage
    import imm_extract_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int XLEN    = 64,
    parameter int IMM_W   = 20,
    localparam int SRC_IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
`ifdef IMM_FLUSH_EN
    input  logic                    flush,
`endif
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_SRC*XLEN-1:0] in_src_data,
    input  logic [IMM_W-1:0]        in_imm,
    input  logic [2:0]              in_imm_type,
    input  logic [SRC_IW-1:0]       in_imm_src,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NUM_SRC*XLEN-1:0] out_src_data
);

    logic signed [31:0]       imm_p0;
    logic signed [XLEN-1:0]   imm_x_p0;
    logic                     rep_p0;
    logic [NUM_SRC*XLEN-1:0]  src_p0;
    logic                     flush_c;

`ifdef IMM_FLUSH_EN
    assign flush_c = flush;
`else
    assign flush_c = 1'b0;
`endif

    // Stage p0: combinational expansion and source replacement
    assign imm_p0   = imm_expand(in_imm, imm_type_e'(in_imm_type));
    assign imm_x_p0 = XLEN'(imm_p0);
    assign rep_p0   = imm_replaces(imm_type_e'(in_imm_type));

    always_comb begin
        src_p0 = in_src_data;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (rep_p0 && int'(in_imm_src) == i) begin
                src_p0[i*XLEN +: XLEN] = imm_x_p0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && in_valid && rep_p0) begin
            assert (int'(in_imm_src) < NUM_SRC);
        end
    end

    // Stage p1: registered skid buffer
    imm_skid_buf2 #(
        .WIDTH (NUM_SRC*XLEN)
    ) u_skid (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush_c),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (src_p0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_src_data)
    );

endmodule

// File: tb/tb_imm_extract_stage.sv
// Directed scoreboard bench for imm_extract_stage (flush steps built when IMM_FLUSH_EN is defined).
`timescale 1ns/1ps
module tb_imm_extract_stage;

    localparam int NUM_SRC = 3;
    localparam int XLEN    = 64;
    localparam int IMM_W   = 20;
    localparam int VW      = NUM_SRC*XLEN;

    localparam logic [2:0] T_NONE = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3;
    localparam logic [2:0] T_U = 3'd4, T_J = 3'd5, T_Z = 3'd6, T_RSV = 3'd7;

    localparam logic [XLEN-1:0] W0 = 64'h1111_2222_3333_4444;
    localparam logic [XLEN-1:0] W1 = 64'h5555_6666_7777_8888;
    localparam logic [XLEN-1:0] W2 = 64'h9999_AAAA_BBBB_CCCC;
    localparam logic [VW-1:0]   SRC_A = {W2, W1, W0};
    localparam logic [VW-1:0]   SRC_B = ~{W2, W1, W0};
    localparam logic [VW-1:0]   SRC_C = {W0, W2, W1};

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [VW-1:0]    in_src_data;
    logic [IMM_W-1:0] in_imm;
    logic [2:0]       in_imm_type;
    logic [1:0]       in_imm_src;
    logic             out_valid;
    logic             out_ready;
    logic [VW-1:0]    out_src_data;
`ifdef IMM_FLUSH_EN
    logic             flush;
`endif

    int            checks = 0;
    int            errors = 0;
    logic [VW-1:0] sb[$];
    logic [VW-1:0] cur_exp;

    always #5 clock = ~clock;

    imm_extract_stage #(
        .NUM_SRC (NUM_SRC),
        .XLEN    (XLEN),
        .IMM_W   (IMM_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
`ifdef IMM_FLUSH_EN
        .flush        (flush),
`endif
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_src_data  (in_src_data),
        .in_imm       (in_imm),
        .in_imm_type  (in_imm_type),
        .in_imm_src   (in_imm_src),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_src_data (out_src_data)
    );

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one uop; word is the literal value expected in the selected source slot.
    task automatic drive(input logic [2:0] t, input logic [IMM_W-1:0] imm, input logic [1:0] idx,
                         input logic [XLEN-1:0] word, input logic [VW-1:0] src);
        in_valid    = 1'b1;
        in_imm_type = t;
        in_imm      = imm;
        in_imm_src  = idx;
        in_src_data = src;
        cur_exp     = src;
        cur_exp[int'(idx)*XLEN +: XLEN] = word;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_imm   = '0;
    endtask

    // One clock: check flags and head against the model, then advance the model with the edge.
    task automatic cycle();
        logic do_push;
        logic do_pop;
        logic clr;
        check("in_ready", VW'(in_ready), VW'(sb.size() < 2));
        check("out_valid", VW'(out_valid), VW'(sb.size() != 0));
        if (sb.size() != 0) check("out_data", out_src_data, sb[0]);
        do_push = in_valid && (sb.size() < 2);
        do_pop  = out_ready && (sb.size() != 0);
        clr     = reset;
`ifdef IMM_FLUSH_EN
        if (flush) clr = 1'b1;
`endif
        if (clr) begin
            do_push = 1'b0;
            do_pop  = 1'b0;
        end
        if (do_pop) void'(sb.pop_front());
        if (do_push) sb.push_back(cur_exp);
        @(posedge clock);
        #1;
        if (clr) sb.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        out_ready   = 1'b0;
        in_src_data = '0;
        in_imm_type = T_NONE;
        in_imm_src  = 2'd0;
        cur_exp     = '0;
`ifdef IMM_FLUSH_EN
        flush       = 1'b0;
`endif
        idle();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_out_valid", VW'(out_valid), VW'(1'b0));
        check("rst_in_ready", VW'(in_ready), VW'(1'b1));
        check("rst_out_data", out_src_data, '0);

        // I-type into src1, then drain
        out_ready = 1'b1;
        drive(T_I, 20'h00FFF, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF, SRC_A);
        cycle();
        idle();
        cycle();
        cycle();

        // Back-to-back expansions at full throughput
        drive(T_U,   20'h80000, 2'd0, 64'hFFFF_FFFF_8000_0000, SRC_A); cycle();
        drive(T_J,   20'h00001, 2'd2, 64'h0000_0000_0000_0002, SRC_B); cycle();
        drive(T_Z,   20'hFFFFF, 2'd1, 64'h0000_0000_0000_001F, SRC_C); cycle();
        drive(T_S,   20'h007FF, 2'd0, 64'h0000_0000_0000_07FF, SRC_A); cycle();
        drive(T_B,   20'h00800, 2'd2, 64'hFFFF_FFFF_FFFF_F000, SRC_B); cycle();
        drive(T_J,   20'hFFFFF, 2'd1, 64'hFFFF_FFFF_FFFF_FFFE, SRC_C); cycle();
        drive(T_U,   20'h12345, 2'd2, 64'h0000_0000_1234_5000, SRC_A); cycle();
        drive(T_I,   20'h00800, 2'd0, 64'hFFFF_FFFF_FFFF_F800, SRC_B); cycle();
        drive(T_NONE, 20'hFFFFF, 2'd1, W1, SRC_A); cycle();
        drive(T_RSV, 20'h00FFF, 2'd0, W0, SRC_A); cycle();
        idle();
        cycle();
        cycle();

        // Stall: A and B fill the buffer, C waits at the input
        out_ready = 1'b0;
        drive(T_I, 20'h00005, 2'd0, 64'h5, SRC_A); cycle();
        drive(T_I, 20'h00006, 2'd1, 64'h6, SRC_B); cycle();
        drive(T_I, 20'h00007, 2'd2, 64'h7, SRC_C); cycle();
        check("stall_in_ready", VW'(in_ready), VW'(1'b0));
        cycle();
        out_ready = 1'b1;
        cycle();
        cycle();
        idle();
        cycle();
        cycle();

        // Streaming at count=1 with push and pop each cycle
        for (int k = 0; k < 11; k++) begin
            drive(T_NONE, IMM_W'(k), 2'(k % 3), SRC_A[(k % 3)*XLEN +: XLEN],
                  SRC_A ^ {NUM_SRC{XLEN'(k * 32'h0101_0101)}});
            cur_exp = SRC_A ^ {NUM_SRC{XLEN'(k * 32'h0101_0101)}};
            cycle();
        end
        idle();
        cycle();
        cycle();

`ifdef IMM_FLUSH_EN
        // Flush at count=2 drops the buffer and the same-cycle push
        out_ready = 1'b0;
        drive(T_Z, 20'h00003, 2'd0, 64'h3, SRC_A); cycle();
        drive(T_Z, 20'h00004, 2'd1, 64'h4, SRC_B); cycle();
        drive(T_Z, 20'h00009, 2'd2, 64'h9, SRC_C);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        idle();
        check("flush_out_valid", VW'(out_valid), VW'(1'b0));
        out_ready = 1'b1;
        cycle();
        cycle();
`endif

        // Reset at count=2
        out_ready = 1'b0;
        drive(T_U, 20'h00001, 2'd0, 64'h1000, SRC_A); cycle();
        drive(T_U, 20'h00002, 2'd1, 64'h2000, SRC_B); cycle();
        idle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("rst2_out_valid", VW'(out_valid), VW'(1'b0));
        check("rst2_in_ready", VW'(in_ready), VW'(1'b1));
        check("rst2_out_data", out_src_data, '0);
        out_ready = 1'b1;
        drive(T_B, 20'h00002, 2'd2, 64'h4, SRC_C); cycle();
        idle();
        cycle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
